// File: rtl/ht_out_seq.sv
// ht_out_seq -- serial Huffman codeword sequencer.
//
// Holds an 8-entry code table (one entry per character A,B,C,E,I,L,O,V) and,
// on request, streams five codewords MSB-first, one bit per clock, with no
// gaps between codewords.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   ld_valid   code-table write strobe (accepted only in IDLE, without start)
//   ld_idx     table index: 0=A 1=B 2=C 3=E 4=I 5=L 6=O 7=V
//   ld_len     code length 1..7 (0 is stored as 1)
//   ld_code    code bits, right-aligned
//   start      single-cycle request to emit a sequence
//   out_mode   sequence select, sampled with start (0: ILOVE, 1: ICLAB)
//   busy       sequencer active (SEND or DONE)
//   out_valid  out_code carries a valid bit
//   out_code   serial code bit (0 when out_valid is 0)
//   done       one-cycle pulse after the final bit
//
// state  | meaning
// IDLE   | table writable, waiting for start
// SEND   | streaming bits of slots 0..4
// DONE   | one-cycle done pulse, then back to IDLE

module ht_out_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_valid,
  input  logic [2:0] ld_idx,
  input  logic [2:0] ld_len,
  input  logic [6:0] ld_code,
  input  logic       start,
  input  logic       out_mode,
  output logic       busy,
  output logic       out_valid,
  output logic       out_code,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Entry layout: {len[2:0], code[6:0]}
  logic [9:0] tbl [8];

  logic [2:0] slot, slot_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;   // index of the bit currently on out_code
  logic       mode, mode_nxt;
  logic       busy_nxt, out_valid_nxt, out_code_nxt, done_nxt;

  // Character index for a given slot of the selected sequence.
  function automatic logic [2:0] slot_char(input logic m, input logic [2:0] s);
    logic [2:0] c;
    c = 3'd0;
    if (!m) begin
      case (s)
        3'd0:    c = 3'd4;  // I
        3'd1:    c = 3'd5;  // L
        3'd2:    c = 3'd6;  // O
        3'd3:    c = 3'd7;  // V
        3'd4:    c = 3'd3;  // E
        default: c = 3'd0;
      endcase
    end else begin
      case (s)
        3'd0:    c = 3'd4;  // I
        3'd1:    c = 3'd2;  // C
        3'd2:    c = 3'd5;  // L
        3'd3:    c = 3'd0;  // A
        3'd4:    c = 3'd1;  // B
        default: c = 3'd0;
      endcase
    end
    return c;
  endfunction

  // Entry of the first slot (for start), the current slot, and the next slot.
  logic [9:0] st_ent, cur_ent, nx_ent;
  logic [2:0] st_top, nx_top, cur_dn;

  assign st_ent  = tbl[slot_char(out_mode, 3'd0)];
  assign cur_ent = tbl[slot_char(mode, slot)];
  assign nx_ent  = tbl[slot_char(mode, slot + 3'd1)];

  // Stored lengths are never 0, so len-1 cannot wrap.
  assign st_top = st_ent[9:7] - 3'd1;
  assign nx_top = nx_ent[9:7] - 3'd1;
  assign cur_dn = bit_cnt - 3'd1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SEND;
      S_SEND:  if (bit_cnt == 3'd0 && slot == 3'd4) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values; outputs are registered below so the first
  // bit is already on out_code in the cycle after start is sampled.
  always_comb begin
    slot_nxt      = slot;
    bit_cnt_nxt   = bit_cnt;
    mode_nxt      = mode;
    out_valid_nxt = 1'b0;
    out_code_nxt  = 1'b0;
    done_nxt      = 1'b0;
    busy_nxt      = (state_nxt != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) begin
          mode_nxt      = out_mode;
          slot_nxt      = 3'd0;
          bit_cnt_nxt   = st_top;
          out_valid_nxt = 1'b1;
          out_code_nxt  = st_ent[st_top];
        end
      end
      S_SEND: begin
        if (bit_cnt != 3'd0) begin
          bit_cnt_nxt   = cur_dn;
          out_valid_nxt = 1'b1;
          out_code_nxt  = cur_ent[cur_dn];
        end else if (slot != 3'd4) begin
          // Slot boundary: fetch the next entry with no bubble.
          slot_nxt      = slot + 3'd1;
          bit_cnt_nxt   = nx_top;
          out_valid_nxt = 1'b1;
          out_code_nxt  = nx_ent[nx_top];
        end else begin
          slot_nxt    = 3'd0;
          bit_cnt_nxt = 3'd0;
          done_nxt    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      slot      <= 3'd0;
      bit_cnt   <= 3'd0;
      mode      <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_code  <= 1'b0;
      done      <= 1'b0;
    end else begin
      slot      <= slot_nxt;
      bit_cnt   <= bit_cnt_nxt;
      mode      <= mode_nxt;
      busy      <= busy_nxt;
      out_valid <= out_valid_nxt;
      out_code  <= out_code_nxt;
      done      <= done_nxt;
    end
  end

  // Code table; a load that coincides with start is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) tbl[i] <= {3'd1, 7'd0};
    end else if (state == S_IDLE && ld_valid && !start) begin
      tbl[ld_idx] <= {((ld_len == 3'd0) ? 3'd1 : ld_len), ld_code};
    end
  end

endmodule

// File: tb/tb_ht_out_seq.sv
module tb_ht_out_seq;

  logic       clk = 1'b0;
  logic       rst, ld_valid, start, out_mode;
  logic [2:0] ld_idx, ld_len;
  logic [6:0] ld_code;
  logic       busy, out_valid, out_code, done;

  ht_out_seq dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_idx(ld_idx),
    .ld_len(ld_len), .ld_code(ld_code), .start(start), .out_mode(out_mode),
    .busy(busy), .out_valid(out_valid), .out_code(out_code), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: table contents and the expected bit stream.
  int         m_len  [8];
  logic [6:0] m_code [8];
  int         seq [2][5] = '{'{4, 5, 6, 7, 3}, '{4, 2, 5, 0, 1}};
  logic       bits_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_len[i]  = 1;
      m_code[i] = 7'd0;
    end
  endfunction

  function automatic void build(input bit mode);
    bits_q.delete();
    for (int s = 0; s < 5; s++) begin
      int c;
      c = seq[mode][s];
      for (int b = m_len[c] - 1; b >= 0; b--) bits_q.push_back(m_code[c][b]);
    end
  endfunction

  task automatic load(input logic [2:0] idx, input logic [2:0] len, input logic [6:0] code);
    @(negedge clk);
    ld_valid = 1'b1; ld_idx = idx; ld_len = len; ld_code = code;
    @(negedge clk);
    ld_valid = 1'b0;
    m_len[idx]  = (len == 3'd0) ? 1 : int'(len);
    m_code[idx] = code;
  endtask

  // Runs one sequence and checks every cycle. inj: bit index at which start
  // and a load are pulsed mid-stream; rst_at: bit index at which reset is hit;
  // ld_same: pulse a load together with start.
  task automatic run(input bit mode, input int inj, input int rst_at, input bit ld_same);
    build(mode);
    @(negedge clk);
    start = 1'b1; out_mode = mode;
    if (ld_same) begin
      ld_valid = 1'b1; ld_idx = 3'd4; ld_len = 3'd7; ld_code = 7'h55;
    end
    @(negedge clk);
    start = 1'b0; ld_valid = 1'b0;
    for (int i = 0; i < bits_q.size(); i++) begin
      chk($sformatf("out_valid[%0d]", i), out_valid, 1);
      chk($sformatf("out_code[%0d]", i), out_code, bits_q[i]);
      chk($sformatf("busy[%0d]", i), busy, 1);
      chk($sformatf("done_low[%0d]", i), done, 0);
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_done", done, 0);
        model_reset();
        return;
      end
      if (i == inj) begin
        start = 1'b1; out_mode = ~mode;
        ld_valid = 1'b1; ld_idx = 3'd4; ld_len = 3'd7; ld_code = 7'h7F;
      end
      @(negedge clk);
      start = 1'b0; ld_valid = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("done_out_valid", out_valid, 0);
    chk("done_out_code", out_code, 0);
    chk("done_busy", busy, 1);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; ld_valid = 1'b0; start = 1'b0; out_mode = 1'b0;
    ld_idx = 3'd0; ld_len = 3'd0; ld_code = 7'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_code", out_code, 0);
    chk("reset_done", done, 0);

    // Reset wins over start and load in the same cycle
    @(negedge clk);
    rst = 1'b1; start = 1'b1; ld_valid = 1'b1; ld_idx = 3'd4; ld_len = 3'd3; ld_code = 7'h7;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; ld_valid = 1'b0;
    chk("rst_prio_busy", busy, 0);
    chk("rst_prio_out_valid", out_valid, 0);

    // Reset table: five 0 bits
    run(1'b0, -1, -1, 1'b0);

    // ILOVE with a loaded table: 1011010111000
    load(3'd4, 3'd2, 7'b10);
    load(3'd5, 3'd3, 7'b110);
    load(3'd6, 3'd1, 7'b1);
    load(3'd7, 3'd4, 7'b0111);
    load(3'd3, 3'd3, 7'b000);
    run(1'b0, -1, -1, 1'b0);

    // ICLAB: 10 111 110 0100 0101
    load(3'd2, 3'd3, 7'b111);
    load(3'd0, 3'd4, 7'b0100);
    load(3'd1, 3'd4, 7'b0101);
    run(1'b1, -1, -1, 1'b0);

    // start + load during SEND are ignored; next run keeps the old I code
    run(1'b0, 3, -1, 1'b0);
    run(1'b0, -1, -1, 1'b0);

    // start + load in the same IDLE cycle: load dropped
    run(1'b1, -1, -1, 1'b1);
    run(1'b0, -1, -1, 1'b0);

    // Reset on the 3rd valid bit, then the reset table is emitted
    run(1'b0, -1, 2, 1'b0);
    run(1'b0, -1, -1, 1'b0);

    // ld_len=0 stores length 1
    load(3'd4, 3'd0, 7'h7F);
    run(1'b0, -1, -1, 1'b0);

    // All 7-bit codes: 35 contiguous bits
    for (int i = 0; i < 8; i++) load(3'(i), 3'd7, 7'($urandom));
    run(1'b0, -1, -1, 1'b0);
    run(1'b1, -1, -1, 1'b0);

    // Randomized tables and modes
    repeat (25) begin
      repeat ($urandom_range(0, 4))
        load(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 7'($urandom));
      run(1'($urandom_range(0, 1)), -1, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
